alu_multiciclo: RTL and testbench
=================================

ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits; shift amount width is $clog2(WIDTH).
REQ-002 The block SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port START  input  1  request to execute one operation.
REQ-005 The block SHALL have port ALUSELECT  input  4  operation code from the ALU control decoder.
REQ-006 The block SHALL have ports A and B  input  WIDTH  operands (rs1, rs2/immediate).
REQ-007 The block SHALL have port RESULT  output  WIDTH  registered operation result.
REQ-008 The block SHALL have port BRANCH  output  1  registered branch-taken flag.
REQ-009 The block SHALL have port ZERO  output  1  high when RESULT equals 0, derived combinationally from RESULT.
REQ-010 The block SHALL have port BUSY  output  1  high while an iterative shift is in progress.
REQ-011 The block SHALL have port DONE  output  1  one-cycle pulse marking RESULT/BRANCH valid.

Function
REQ-012 ALUSELECT decode SHALL be: 0000 ADD, 0001 AND, 0010 OR, 0011 SLL, 0100 SLT (signed, result 1/0), 0101 SRL (logical), 0110 SUB, 0111 XOR, 1000 BEQ, 1001 BNE, 1010 BLT (signed), 1011 BGE (signed).
REQ-013 Codes 1100-1111 SHALL produce RESULT=0, BRANCH=0, latency 1.
REQ-014 Branch codes SHALL set RESULT=A-B (mod 2^WIDTH) and BRANCH=condition; all non-branch codes SHALL set BRANCH=0.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH; no carry/overflow output.
REQ-016 FSM SHALL have two states: IDLE and SHIFT.
REQ-017 START SHALL be accepted only in IDLE; A, B, ALUSELECT SHALL be sampled on the accepting edge.
REQ-018 Non-shift ops and shifts with B[$clog2(WIDTH)-1:0]=0 SHALL update RESULT/BRANCH and pulse DONE on the accepting edge+1 (latency 1), staying in IDLE.
REQ-019 Shifts with amount N>0 SHALL load A into an internal register, go to SHIFT, shift one bit per cycle, and update RESULT and pulse DONE at the accepting edge+N, returning to IDLE on that same edge.
REQ-020 BUSY SHALL equal (state==SHIFT); START while BUSY SHALL be ignored without side effects.
REQ-021 START asserted in the cycle DONE is high (state IDLE) SHALL be accepted, giving back-to-back operation.
REQ-022 Upper bits of B beyond the shift-amount field SHALL be ignored for SLL/SRL.
REQ-023 RESULT and BRANCH SHALL hold their last value until the next DONE; DONE SHALL never be high two cycles in a row for a single operation.

Reset
REQ-024 RESET high SHALL immediately force state=IDLE, RESULT=0, BRANCH=0, BUSY=0, DONE=0, hence ZERO=1.
REQ-025 RESET during SHIFT SHALL abort the operation with no DONE pulse; START is ignored while RESET is high.
REQ-026 After RESET release the first START SHALL behave as from a clean IDLE.

Verification
REQ-027 Reset: assert RESET asynchronously mid-cycle -> RESULT=0, BRANCH=0, BUSY=0, DONE=0, ZERO=1 without waiting for CLK.
REQ-028 ALU ops: ALUSELECT=0110, A=5, B=7 -> DONE one cycle later, RESULT=0xFFFFFFFE, ZERO=0; 0100 A=0xFFFFFFFF B=1 -> RESULT=1.
REQ-029 Shift: ALUSELECT=0011, A=1, B=0x25 (amount 5) -> BUSY high 5 cycles... DONE at accept+5, RESULT=0x20; amount 0 -> DONE at accept+1, RESULT=A.
REQ-030 Branch: 1010 A=0x80000000 B=1 -> BRANCH=1; 1011 same operands -> BRANCH=0; 1000 A=B=9 -> BRANCH=1, ZERO=1.
REQ-031 Handshake: START held high during SRL of amount 3 -> second op not started until DONE cycle, then accepted back-to-back; START during BUSY produces no extra DONE.
REQ-032 Abort: RESET at cycle 2 of an SLL with amount 10 -> no DONE, outputs at reset values, next ADD 2+3 -> RESULT=5 at latency 1.

Source files
------------

// File: rtl/alu_multiciclo_if.sv
// Operand/result bundle for alu_multiciclo: request side (START, ALUSELECT, A, B)
// and completion side (RESULT, BRANCH, ZERO, BUSY, DONE).
interface alu_multiciclo_if #(
   parameter int WIDTH = 32
);
   logic             START;
   logic [3:0]       ALUSELECT;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] RESULT;
   logic             BRANCH;
   logic             ZERO;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, ALUSELECT, A, B,
      input  RESULT, BRANCH, ZERO, BUSY, DONE
   );

   modport slave (
      input  START, ALUSELECT, A, B,
      output RESULT, BRANCH, ZERO, BUSY, DONE
   );
endinterface

// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-edge ops finish on the accepting edge; SLL/SRL shift one bit per cycle.
// Latency: 1 cycle (non-shift or amount 0), else DONE at accept edge + N; START ignored while BUSY.
module alu_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   alu_multiciclo_if.slave  bus
);

   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SLT = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;
   localparam logic [3:0] OP_BGE = 4'b1011;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             branch_q, branch_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             left_q, left_d;

   logic [WIDTH-1:0] diff;
   logic             lt;
   logic [SW-1:0]    amt;
   logic             is_shift;
   logic [WIDTH-1:0] alu_res;
   logic             alu_br;
   logic [WIDTH-1:0] shifted;

   assign diff     = bus.A - bus.B;
   assign lt       = $signed(bus.A) < $signed(bus.B);
   assign amt      = bus.B[SW-1:0];
   assign is_shift = (bus.ALUSELECT == OP_SLL) || (bus.ALUSELECT == OP_SRL);
   assign shifted  = left_q ? (shreg_q << 1) : (shreg_q >> 1);

   // Shift codes report A here; that value is only used when the amount is zero.
   always_comb begin
      alu_res = '0;
      alu_br  = 1'b0;
      case (bus.ALUSELECT)
         OP_ADD:  alu_res = bus.A + bus.B;
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_SLL:  alu_res = bus.A;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
         OP_SRL:  alu_res = bus.A;
         OP_SUB:  alu_res = diff;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_BEQ: begin alu_res = diff; alu_br = (diff == '0); end
         OP_BNE: begin alu_res = diff; alu_br = (diff != '0); end
         OP_BLT: begin alu_res = diff; alu_br = lt;           end
         OP_BGE: begin alu_res = diff; alu_br = !lt;          end
         default: begin alu_res = '0; alu_br = 1'b0;          end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      branch_d = branch_q;
      done_d   = 1'b0;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               if (is_shift && (amt != '0)) begin
                  state_d = SHIFT;
                  shreg_d = bus.A;
                  cnt_d   = amt;
                  left_d  = (bus.ALUSELECT == OP_SLL);
               end else begin
                  result_d = alu_res;
                  branch_d = alu_br;
                  done_d   = 1'b1;
               end
            end
         end
         SHIFT: begin
            shreg_d = shifted;
            cnt_d   = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               result_d = shifted;
               branch_d = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         result_q <= '0;
         branch_q <= 1'b0;
         done_q   <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         branch_q <= branch_d;
         done_q   <= done_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
      end
   end

   assign bus.RESULT = result_q;
   assign bus.BRANCH = branch_q;
   assign bus.ZERO   = (result_q == '0);
   assign bus.BUSY   = (state_q == SHIFT);
   assign bus.DONE   = done_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: ALU/branch vectors, iterative shifts, handshake and reset abort.
module tb_alu_multiciclo;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;

   alu_multiciclo_if #(.WIDTH(32)) bus ();

   alu_multiciclo #(.WIDTH(32)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents one request for one cycle; returns edges after the accept edge until DONE,
   // and the number of sampled cycles with BUSY high in that window.
   task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output int n, output int busy);
      bus.START     = 1'b1;
      bus.ALUSELECT = sel;
      bus.A         = a;
      bus.B         = b;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      n    = 0;
      busy = 0;
      while (!bus.DONE && n < 100) begin
         if (bus.BUSY) busy++;
         @(posedge CLK); #1;
         n++;
      end
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br,
                          input int exp_n);
      int n, busy;
      run_op(sel, a, b, n, busy);
      chk({tag, ".edges"}, n, exp_n);
      chk({tag, ".busy"}, busy, exp_n);
      chk({tag, ".done"}, bus.DONE, 1'b1);
      chk({tag, ".res"}, bus.RESULT, exp_res);
      chk({tag, ".br"}, bus.BRANCH, exp_br);
      chk({tag, ".zero"}, bus.ZERO, exp_res == 32'h0);
      @(posedge CLK); #1;
      chk({tag, ".pulse"}, bus.DONE, 1'b0);
      chk({tag, ".hold"}, bus.RESULT, exp_res);
   endtask

   initial begin
      int dones;
      bus.START     = 1'b0;
      bus.ALUSELECT = 4'h0;
      bus.A         = 32'h0;
      bus.B         = 32'h0;

      // Asynchronous reset, observed before any clock edge.
      #1 RESET = 1'b1;
      #1;
      chk("rst.res", bus.RESULT, 32'h0);
      chk("rst.br", bus.BRANCH, 1'b0);
      chk("rst.busy", bus.BUSY, 1'b0);
      chk("rst.done", bus.DONE, 1'b0);
      chk("rst.zero", bus.ZERO, 1'b1);
      @(posedge CLK);
      @(posedge CLK); #1;
      RESET = 1'b0;

      alu_vec("sub",    4'b0110, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 0);
      alu_vec("slt",    4'b0100, 32'hFFFF_FFFF, 32'd1,       32'd1,         1'b0, 0);
      alu_vec("slt_f",  4'b0100, 32'd5,        32'd3,        32'd0,         1'b0, 0);
      alu_vec("add",    4'b0000, 32'hFFFF_FFFF, 32'd2,       32'd1,         1'b0, 0);
      alu_vec("and",    4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0);
      alu_vec("or",     4'b0010, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0, 0);
      alu_vec("xor",    4'b0111, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 0);
      alu_vec("op_c",   4'b1100, 32'd5,        32'd7,        32'd0,         1'b0, 0);
      alu_vec("op_f",   4'b1111, 32'd9,        32'd1,        32'd0,         1'b0, 0);
      alu_vec("sll5",   4'b0011, 32'd1,        32'h25,       32'h20,        1'b0, 5);
      alu_vec("sll0",   4'b0011, 32'h1234,     32'h20,       32'h1234,      1'b0, 0);
      alu_vec("srl31",  4'b0101, 32'h8000_0000, 32'h1F,      32'd1,         1'b0, 31);
      alu_vec("srl_hb", 4'b0101, 32'hF0,       32'hFFFF_FFE4, 32'h0F,       1'b0, 4);
      alu_vec("blt",    4'b1010, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b1, 0);
      alu_vec("bge",    4'b1011, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, 0);
      alu_vec("beq",    4'b1000, 32'd9,        32'd9,        32'd0,         1'b1, 0);
      alu_vec("bne",    4'b1001, 32'd9,        32'd9,        32'd0,         1'b0, 0);
      alu_vec("bne_t",  4'b1001, 32'd9,        32'd4,        32'd5,         1'b1, 0);
      alu_vec("add_nb", 4'b0000, 32'd2,        32'd3,        32'd5,         1'b0, 0);

      // START held through an SRL by 3: the queued ADD is taken only in the DONE cycle.
      bus.START     = 1'b1;
      bus.ALUSELECT = 4'b0101;
      bus.A         = 32'h80;
      bus.B         = 32'd3;
      @(posedge CLK); #1;
      chk("hs.e0.busy", bus.BUSY, 1'b1);
      chk("hs.e0.done", bus.DONE, 1'b0);
      bus.ALUSELECT = 4'b0000;
      bus.A         = 32'd2;
      bus.B         = 32'd3;
      dones = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1;
         if (bus.DONE) dones++;
         chk("hs.busy", bus.BUSY, 1'b1);
      end
      chk("hs.no_extra_done", dones, 0);
      @(posedge CLK); #1;
      chk("hs.e3.done", bus.DONE, 1'b1);
      chk("hs.e3.res", bus.RESULT, 32'h10);
      chk("hs.e3.busy", bus.BUSY, 1'b0);
      @(posedge CLK); #1;
      bus.START = 1'b0;
      chk("hs.e4.done", bus.DONE, 1'b1);
      chk("hs.e4.res", bus.RESULT, 32'd5);
      @(posedge CLK); #1;
      chk("hs.e5.done", bus.DONE, 1'b0);
      chk("hs.e5.res", bus.RESULT, 32'd5);

      // Reset in the second cycle of an SLL by 10 aborts it with no DONE.
      bus.START     = 1'b1;
      bus.ALUSELECT = 4'b0011;
      bus.A         = 32'd1;
      bus.B         = 32'd10;
      @(posedge CLK); #1;
      bus.START = 1'b0;
      chk("ab.busy0", bus.BUSY, 1'b1);
      @(posedge CLK); #2;
      RESET         = 1'b1;
      bus.START     = 1'b1;
      bus.ALUSELECT = 4'b0000;
      bus.A         = 32'd7;
      bus.B         = 32'd8;
      #1;
      chk("ab.res", bus.RESULT, 32'h0);
      chk("ab.br", bus.BRANCH, 1'b0);
      chk("ab.busy", bus.BUSY, 1'b0);
      chk("ab.done", bus.DONE, 1'b0);
      chk("ab.zero", bus.ZERO, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(posedge CLK); #1;
         chk("ab.rst_start_ign", {bus.DONE, bus.BUSY}, 2'b00);
         chk("ab.rst_res", bus.RESULT, 32'h0);
      end
      bus.START = 1'b0;
      RESET     = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK); #1;
         if (bus.DONE) dones++;
      end
      chk("ab.no_done", dones, 0);
      chk("ab.res_kept", bus.RESULT, 32'h0);
      alu_vec("post_add", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
